// File: rtl/lc3_mc_control_if.sv
// Memory handshake between the LC-3 multicycle controller and the memory port.
interface lc3_mc_control_if;
    logic       mem_req;
    logic       mem_we;
    logic [1:0] addr_sel;
    logic       mem_ack;

    modport master (output mem_req, output mem_we, output addr_sel, input mem_ack);
    modport slave  (input mem_req, input mem_we, input addr_sel, output mem_ack);
endinterface

// File: rtl/lc3_mc_control.sv
// LC-3 multicycle control unit: fetch/decode/execute/memory sequencing with
// per-access stall timeout, HALT and FAULT terminal states.
module lc3_mc_control #(
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    lc3_mc_control_if.master        mem,
    input  logic [15:0]             ir,
    input  logic [2:0]              nzp,
    output logic                    ir_ld,
    output logic                    pc_inc,
    output logic                    pc_ld,
    output logic                    pc_sel,
    output logic                    ptr_ld,
    output logic                    rf_we,
    output logic [2:0]              rf_waddr,
    output logic [2:0]              rf_raddr0,
    output logic [2:0]              rf_raddr1,
    output logic [1:0]              rf_wsel,
    output logic [1:0]              alu_op,
    output logic                    a_sel,
    output logic                    b_sel,
    output logic                    nzp_ld,
    output logic                    nzp_sel,
    output logic                    halted,
    output logic                    fault,
    output logic [2:0]              state_dbg
);
    localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam bit          TO_EN = (MEM_TIMEOUT != 0);
    localparam logic [CW-1:0] CNT_LAST = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM1   = 3'd3,
        S_MEM2   = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam logic [3:0] OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010,
                           OP_ST  = 4'b0011, OP_JSR = 4'b0100, OP_AND = 4'b0101,
                           OP_LDR = 4'b0110, OP_STR = 4'b0111, OP_RTI = 4'b1000,
                           OP_NOT = 4'b1001, OP_LDI = 4'b1010, OP_STI = 4'b1011,
                           OP_JMP = 4'b1100, OP_RES = 4'b1101, OP_LEA = 4'b1110,
                           OP_TRP = 4'b1111;

    localparam logic [1:0] ALU_ADD = 2'd0, ALU_AND = 2'd1, ALU_NOT = 2'd3;
    localparam logic [1:0] ADDR_PC = 2'd0, ADDR_EA = 2'd1, ADDR_PTR = 2'd2;
    localparam logic [1:0] WSEL_PC = 2'd0, WSEL_MEM = 2'd1, WSEL_ALU = 2'd2;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [3:0]    op;
    logic          in_mem, stall, timeout, br_taken, is_mem_op, is_ind, is_load;
    logic          unused_ir;

    assign op        = ir[15:12];
    assign unused_ir = ^ir[4:3];
    assign in_mem    = (state_q == S_FETCH) || (state_q == S_MEM1) || (state_q == S_MEM2);
    assign stall     = in_mem && !mem.mem_ack;
    assign timeout   = TO_EN && stall && (cnt_q == CNT_LAST);
    assign br_taken  = (ir[11] & nzp[2]) | (ir[10] & nzp[1]) | (ir[9] & nzp[0]);
    assign is_mem_op = op inside {OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI};
    assign is_ind    = (op == OP_LDI) || (op == OP_STI);
    assign is_load   = (op == OP_LD) || (op == OP_LDR);
    assign state_dbg = state_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Stall counter: restarts on every new access and on each acknowledge
    always_ff @(posedge clk) begin
        if (rst || !stall || (state_d != state_q)) cnt_q <= '0;
        else                                       cnt_q <= cnt_q + CW'(1);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem.mem_ack) state_d = S_DECODE;
            S_DECODE: begin
                if (op == OP_TRP)                        state_d = S_HALT;
                else if ((op == OP_RTI) || (op == OP_RES)) state_d = S_FAULT;
                else                                     state_d = S_EXEC;
            end
            S_EXEC:   state_d = is_mem_op ? S_MEM1 : S_FETCH;
            S_MEM1:   if (mem.mem_ack) state_d = is_ind ? S_MEM2 : S_FETCH;
            S_MEM2:   if (mem.mem_ack) state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FAULT;
        endcase
        if (timeout) state_d = S_FAULT;
    end

    // Output decode
    always_comb begin
        mem.mem_req  = 1'b0;
        mem.mem_we   = 1'b0;
        mem.addr_sel = ADDR_PC;
        ir_ld = 1'b0;  pc_inc = 1'b0;  pc_ld = 1'b0;  pc_sel = 1'b0;  ptr_ld = 1'b0;
        rf_we = 1'b0;  rf_waddr = 3'd0; rf_raddr0 = 3'd0; rf_raddr1 = 3'd0; rf_wsel = WSEL_PC;
        alu_op = ALU_ADD; a_sel = 1'b0; b_sel = 1'b0; nzp_ld = 1'b0; nzp_sel = 1'b0;
        halted = 1'b0; fault = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem.mem_req = 1'b1;
                if (mem.mem_ack) begin
                    ir_ld  = 1'b1;
                    pc_inc = 1'b1;
                end
            end
            S_DECODE: ;
            S_EXEC: begin
                case (op)
                    OP_ADD, OP_AND, OP_NOT: begin
                        rf_we     = 1'b1;
                        nzp_ld    = 1'b1;
                        rf_waddr  = ir[11:9];
                        rf_raddr0 = ir[8:6];
                        rf_raddr1 = ir[2:0];
                        a_sel     = 1'b1;
                        b_sel     = ir[5];
                        alu_op    = (op == OP_ADD) ? ALU_ADD : (op == OP_AND) ? ALU_AND : ALU_NOT;
                    end
                    OP_BR:  pc_ld = br_taken;
                    OP_JMP: begin
                        pc_ld     = 1'b1;
                        pc_sel    = 1'b1;
                        rf_raddr0 = ir[8:6];
                    end
                    // R7 captures the pre-jump PC on the same edge the PC is reloaded
                    OP_JSR: begin
                        rf_we     = 1'b1;
                        rf_waddr  = 3'd7;
                        rf_wsel   = WSEL_PC;
                        pc_ld     = 1'b1;
                        pc_sel    = ~ir[11];
                        rf_raddr0 = ir[8:6];
                    end
                    OP_LEA: begin
                        rf_we    = 1'b1;
                        rf_wsel  = WSEL_ALU;
                        b_sel    = 1'b1;
                        alu_op   = ALU_ADD;
                        rf_waddr = ir[11:9];
                    end
                    default: ;
                endcase
            end
            S_MEM1: begin
                mem.mem_req  = 1'b1;
                mem.addr_sel = ADDR_EA;
                mem.mem_we   = (op == OP_ST) || (op == OP_STR);
                rf_raddr0    = ir[8:6];
                rf_raddr1    = ir[11:9];
                if (mem.mem_ack) begin
                    if (is_load) begin
                        rf_we    = 1'b1;
                        rf_wsel  = WSEL_MEM;
                        rf_waddr = ir[11:9];
                        nzp_ld   = 1'b1;
                        nzp_sel  = 1'b1;
                    end
                    ptr_ld = is_ind;
                end
            end
            S_MEM2: begin
                mem.mem_req  = 1'b1;
                mem.addr_sel = ADDR_PTR;
                mem.mem_we   = (op == OP_STI);
                if (mem.mem_ack && (op == OP_LDI)) begin
                    rf_we    = 1'b1;
                    rf_wsel  = WSEL_MEM;
                    rf_waddr = ir[11:9];
                    nzp_ld   = 1'b1;
                    nzp_sel  = 1'b1;
                end
            end
            S_HALT:  halted = 1'b1;
            default: fault  = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_lc3_mc_control.sv
// Directed bench for lc3_mc_control: every control output is compared each
// checked cycle against a hand-built expected control word.
module tb_lc3_mc_control;
    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir;
    logic [2:0]  nzp;
    logic        ir_ld, pc_inc, pc_ld, pc_sel, ptr_ld, rf_we;
    logic [2:0]  rf_waddr, rf_raddr0, rf_raddr1;
    logic [1:0]  rf_wsel, alu_op;
    logic        a_sel, b_sel, nzp_ld, nzp_sel, halted, fault;
    logic [2:0]  state_dbg;

    lc3_mc_control_if mif ();

    lc3_mc_control #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .mem(mif.master), .ir(ir), .nzp(nzp),
        .ir_ld(ir_ld), .pc_inc(pc_inc), .pc_ld(pc_ld), .pc_sel(pc_sel), .ptr_ld(ptr_ld),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1),
        .rf_wsel(rf_wsel), .alu_op(alu_op), .a_sel(a_sel), .b_sel(b_sel),
        .nzp_ld(nzp_ld), .nzp_sel(nzp_sel), .halted(halted), .fault(fault),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic [1:0] addr_sel;
        logic       ir_ld;
        logic       pc_inc;
        logic       pc_ld;
        logic       pc_sel;
        logic       ptr_ld;
        logic       rf_we;
        logic [2:0] rf_waddr;
        logic [2:0] rf_raddr0;
        logic [2:0] rf_raddr1;
        logic [1:0] rf_wsel;
        logic [1:0] alu_op;
        logic       a_sel;
        logic       b_sel;
        logic       nzp_ld;
        logic       nzp_sel;
        logic       halted;
        logic       fault;
        logic [2:0] state;
    } ctl_t;

    ctl_t obs;
    assign obs = {mif.mem_req, mif.mem_we, mif.addr_sel, ir_ld, pc_inc, pc_ld, pc_sel,
                  ptr_ld, rf_we, rf_waddr, rf_raddr0, rf_raddr1, rf_wsel, alu_op,
                  a_sel, b_sel, nzp_ld, nzp_sel, halted, fault, state_dbg};

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input ctl_t e);
        n_cmp++;
        assert (obs === e) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, e);
        end
    endtask

    // Apply ack, let combinational outputs settle, compare, advance one clock
    task automatic cyc(input string tag, input logic ack, input ctl_t e);
        mif.mem_ack = ack;
        #1;
        chk(tag, e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic ctl_t st_e(input logic [2:0] s);
        ctl_t e;
        e = '0;
        e.state = s;
        return e;
    endfunction

    function automatic ctl_t fetch_e(input logic ack);
        ctl_t e;
        e = st_e(3'd0);
        e.mem_req = 1'b1;
        e.ir_ld   = ack;
        e.pc_inc  = ack;
        return e;
    endfunction

    task automatic fd(input string tag, input logic [15:0] instr);
        ir = instr;
        cyc({tag, "_fetch"}, 1'b1, fetch_e(1'b1));
        cyc({tag, "_decode"}, 1'b0, st_e(3'd1));
    endtask

    ctl_t e;

    initial begin
        rst = 1'b1; ir = 16'h0000; nzp = 3'b000; mif.mem_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #1; chk("reset_held", fetch_e(1'b0));
        rst = 1'b0;
        cyc("reset_fetch", 1'b0, fetch_e(1'b0));

        // ADD R0,R1,R2 with an ack during DECODE that must be ignored
        ir = 16'h1042;
        cyc("add_fetch", 1'b1, fetch_e(1'b1));
        cyc("add_decode_ack", 1'b1, st_e(3'd1));
        e = st_e(3'd2); e.rf_we = 1; e.nzp_ld = 1; e.rf_waddr = 3'd0;
        e.rf_raddr0 = 3'd1; e.rf_raddr1 = 3'd2; e.a_sel = 1;
        cyc("add_exec", 1'b0, e);

        fd("and", 16'h5A7F);
        e = st_e(3'd2); e.rf_we = 1; e.nzp_ld = 1; e.rf_waddr = 3'd5; e.rf_raddr0 = 3'd1;
        e.rf_raddr1 = 3'd7; e.a_sel = 1; e.b_sel = 1; e.alu_op = 2'd1;
        cyc("and_exec", 1'b0, e);

        fd("not", 16'h927F);
        e = st_e(3'd2); e.rf_we = 1; e.nzp_ld = 1; e.rf_waddr = 3'd1; e.rf_raddr0 = 3'd1;
        e.rf_raddr1 = 3'd7; e.a_sel = 1; e.b_sel = 1; e.alu_op = 2'd3;
        cyc("not_exec", 1'b0, e);

        fd("lea", 16'hE802);
        e = st_e(3'd2); e.rf_we = 1; e.rf_wsel = 2'd2; e.b_sel = 1; e.rf_waddr = 3'd4;
        cyc("lea_exec", 1'b0, e);

        nzp = 3'b010;
        fd("br_taken", 16'h0403);
        e = st_e(3'd2); e.pc_ld = 1;
        cyc("br_taken_exec", 1'b0, e);
        nzp = 3'b001;
        fd("br_not", 16'h0403);
        cyc("br_not_exec", 1'b0, st_e(3'd2));

        fd("jsrr", 16'h4080);
        e = st_e(3'd2); e.rf_we = 1; e.rf_waddr = 3'd7; e.pc_ld = 1; e.pc_sel = 1; e.rf_raddr0 = 3'd2;
        cyc("jsrr_exec", 1'b0, e);
        fd("jsr", 16'h4800);
        e = st_e(3'd2); e.rf_we = 1; e.rf_waddr = 3'd7; e.pc_ld = 1;
        cyc("jsr_exec", 1'b0, e);
        fd("jmp", 16'hC1C0);
        e = st_e(3'd2); e.pc_ld = 1; e.pc_sel = 1; e.rf_raddr0 = 3'd7;
        cyc("jmp_exec", 1'b0, e);

        // LDI R2 with two stall cycles on each access
        fd("ldi", 16'hA405);
        cyc("ldi_exec", 1'b0, st_e(3'd2));
        e = st_e(3'd3); e.mem_req = 1; e.addr_sel = 2'd1; e.rf_raddr1 = 3'd2;
        cyc("ldi_m1_stall0", 1'b0, e);
        cyc("ldi_m1_stall1", 1'b0, e);
        e.ptr_ld = 1;
        cyc("ldi_m1_ack", 1'b1, e);
        e = st_e(3'd4); e.mem_req = 1; e.addr_sel = 2'd2;
        cyc("ldi_m2_stall0", 1'b0, e);
        cyc("ldi_m2_stall1", 1'b0, e);
        e.rf_we = 1; e.rf_wsel = 2'd1; e.rf_waddr = 3'd2; e.nzp_ld = 1; e.nzp_sel = 1;
        cyc("ldi_m2_ack", 1'b1, e);

        // STI: mem_we only during MEM2
        fd("sti", 16'hB605);
        cyc("sti_exec", 1'b0, st_e(3'd2));
        e = st_e(3'd3); e.mem_req = 1; e.addr_sel = 2'd1; e.rf_raddr1 = 3'd3; e.ptr_ld = 1;
        cyc("sti_m1_ack", 1'b1, e);
        e = st_e(3'd4); e.mem_req = 1; e.mem_we = 1; e.addr_sel = 2'd2;
        cyc("sti_m2_stall", 1'b0, e);
        cyc("sti_m2_ack", 1'b1, e);

        fd("st", 16'h3E01);
        cyc("st_exec", 1'b0, st_e(3'd2));
        e = st_e(3'd3); e.mem_req = 1; e.mem_we = 1; e.addr_sel = 2'd1; e.rf_raddr1 = 3'd7;
        cyc("st_m1_stall", 1'b0, e);
        cyc("st_m1_ack", 1'b1, e);

        // LD: ack arrives on the cycle the timeout would fire and must win
        fd("ld", 16'h2605);
        cyc("ld_exec", 1'b0, st_e(3'd2));
        e = st_e(3'd3); e.mem_req = 1; e.addr_sel = 2'd1; e.rf_raddr1 = 3'd3;
        cyc("ld_m1_stall0", 1'b0, e);
        cyc("ld_m1_stall1", 1'b0, e);
        cyc("ld_m1_stall2", 1'b0, e);
        e.rf_we = 1; e.rf_wsel = 2'd1; e.rf_waddr = 3'd3; e.nzp_ld = 1; e.nzp_sel = 1;
        cyc("ld_m1_ack_at_limit", 1'b1, e);

        // Fetch timeout after four unacknowledged cycles
        for (int i = 0; i < 4; i++) cyc("to_fetch_stall", 1'b0, fetch_e(1'b0));
        e = st_e(3'd6); e.fault = 1;
        cyc("to_fault", 1'b1, e);
        cyc("to_fault_absorb", 1'b1, e);
        mif.mem_ack = 1'b0;
        do_reset();
        cyc("to_after_rst", 1'b0, fetch_e(1'b0));

        fd("illegal", 16'hD000);
        e = st_e(3'd6); e.fault = 1;
        cyc("illegal_fault", 1'b0, e);
        do_reset();

        fd("halt", 16'hF025);
        e = st_e(3'd5); e.halted = 1;
        for (int i = 0; i < 20; i++) cyc("halt_hold", logic'(i[0]), e);
        mif.mem_ack = 1'b0;
        do_reset();

        // Reset mid-MEM1 (with a concurrent ack) returns to FETCH, counter cleared
        fd("rstmem", 16'h2605);
        cyc("rstmem_exec", 1'b0, st_e(3'd2));
        e = st_e(3'd3); e.mem_req = 1; e.addr_sel = 2'd1; e.rf_raddr1 = 3'd3;
        cyc("rstmem_m1_stall0", 1'b0, e);
        cyc("rstmem_m1_stall1", 1'b0, e);
        mif.mem_ack = 1'b1;
        do_reset();
        cyc("rstmem_fetch0", 1'b0, fetch_e(1'b0));
        cyc("rstmem_fetch1", 1'b0, fetch_e(1'b0));
        cyc("rstmem_fetch2", 1'b0, fetch_e(1'b0));
        cyc("rstmem_fetch_ack", 1'b1, fetch_e(1'b1));
        cyc("rstmem_decode", 1'b0, st_e(3'd1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
